// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw level in, debounced level, strobes and status out.
// Combinational wiring only; strobes are free-running and have no backpressure.
interface button_debouncer_if;
    logic       button_raw;
    logic       button;
    logic       press_pulse;
    logic       release_pulse;
    logic       busy;
    logic [7:0] bounce_count;

    modport master (
        output button_raw,
        input  button, press_pulse, release_pulse, busy, bounce_count
    );

    modport slave (
        input  button_raw,
        output button, press_pulse, release_pulse, busy, bounce_count
    );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchroniser chain feeding a 4-state qualifier FSM with registered outputs.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges; no backpressure, strobes are single-cycle and free-running.
module button_debouncer #(
    parameter int SYNC_STAGES     = 2,   // 2..4
    parameter int DEBOUNCE_CYCLES = 16   // 2..65535
) (
    input  logic               clk,
    input  logic               rst_n,
    button_debouncer_if.slave  dbif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   button_q;
    logic                   press_q;
    logic                   release_q;
    logic                   busy_q;
    logic [7:0]             bounce_q;

    // Only the first stage ever sees the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], dbif.button_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE_LOW;
            cnt       <= '0;
            button_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            busy_q    <= 1'b0;
            bounce_q  <= 8'd0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    button_q <= 1'b0;
                    if (s) begin
                        state  <= WAIT_HIGH;
                        cnt    <= CNT_ONE;
                        busy_q <= 1'b1;
                    end else begin
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end
                end
                WAIT_HIGH: begin
                    if (s) begin
                        if (cnt == CNT_LAST) begin
                            state    <= IDLE_HIGH;
                            cnt      <= '0;
                            button_q <= 1'b1;
                            press_q  <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        state  <= IDLE_LOW;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        if (bounce_q != 8'hFF) bounce_q <= bounce_q + 8'd1;
                    end
                end
                IDLE_HIGH: begin
                    button_q <= 1'b1;
                    if (!s) begin
                        state  <= WAIT_LOW;
                        cnt    <= CNT_ONE;
                        busy_q <= 1'b1;
                    end else begin
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end
                end
                WAIT_LOW: begin
                    if (!s) begin
                        if (cnt == CNT_LAST) begin
                            state     <= IDLE_LOW;
                            cnt       <= '0;
                            button_q  <= 1'b0;
                            release_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        state  <= IDLE_HIGH;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        if (bounce_q != 8'hFF) bounce_q <= bounce_q + 8'd1;
                    end
                end
                // Recovery path for a corrupted state register.
                default: begin
                    state    <= IDLE_LOW;
                    cnt      <= '0;
                    button_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dbif.button        = button_q;
    assign dbif.press_pulse   = press_q;
    assign dbif.release_pulse = release_q;
    assign dbif.busy          = busy_q;
    assign dbif.bounce_count  = bounce_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    button_debouncer_if dbif ();

    button_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dbif  (dbif)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_low();
        dbif.button_raw = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        rst_n           = 1'b0;
        dbif.button_raw = 1'b0;
        #12;
        check_eq("rst_button",  32'(dbif.button), 0);
        check_eq("rst_press",   32'(dbif.press_pulse), 0);
        check_eq("rst_release", 32'(dbif.release_pulse), 0);
        check_eq("rst_busy",    32'(dbif.busy), 0);
        check_eq("rst_bounce",  32'(dbif.bounce_count), 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Clean press: accepted on the 6th sampling edge
        dbif.button_raw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check_eq($sformatf("press_btn_e%0d", k),  32'(dbif.button), 32'(k >= 6));
            check_eq($sformatf("press_pls_e%0d", k),  32'(dbif.press_pulse), 32'(k == 6));
            check_eq($sformatf("press_busy_e%0d", k), 32'(dbif.busy), 32'(k >= 3 && k <= 5));
        end

        // Clean release
        dbif.button_raw = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check_eq($sformatf("rel_btn_e%0d", k),  32'(dbif.button), 32'(k < 6));
            check_eq($sformatf("rel_pls_e%0d", k),  32'(dbif.release_pulse), 32'(k == 6));
            check_eq($sformatf("rel_press_e%0d", k), 32'(dbif.press_pulse), 0);
            check_eq($sformatf("rel_busy_e%0d", k), 32'(dbif.busy), 32'(k >= 3 && k <= 5));
        end

        // Bounce: high 3, low 1, then held high; abort at e6, restart at e7, accept at e10
        dbif.button_raw = 1'b1;
        repeat (3) tick();
        dbif.button_raw = 1'b0;
        tick();
        dbif.button_raw = 1'b1;
        tick();
        tick();
        check_eq("bnc_count_e6", 32'(dbif.bounce_count), 1);
        check_eq("bnc_busy_e6",  32'(dbif.busy), 0);
        check_eq("bnc_btn_e6",   32'(dbif.button), 0);
        tick();
        check_eq("bnc_busy_e7",  32'(dbif.busy), 1);
        tick();
        tick();
        check_eq("bnc_btn_e9",   32'(dbif.button), 0);
        check_eq("bnc_pls_e9",   32'(dbif.press_pulse), 0);
        tick();
        check_eq("bnc_btn_e10",  32'(dbif.button), 1);
        check_eq("bnc_pls_e10",  32'(dbif.press_pulse), 1);
        tick();
        check_eq("bnc_pls_e11",  32'(dbif.press_pulse), 0);
        check_eq("bnc_count_e11", 32'(dbif.bounce_count), 1);
        settle_low();
        check_eq("bnc_settled_btn", 32'(dbif.button), 0);

        // Late glitch at cnt=3, then raw stays low: no toggle at all
        dbif.button_raw = 1'b1;
        repeat (3) tick();
        dbif.button_raw = 1'b0;
        tick();
        tick();
        check_eq("gl_busy_e5",  32'(dbif.busy), 1);
        tick();
        check_eq("gl_busy_e6",  32'(dbif.busy), 0);
        check_eq("gl_count_e6", 32'(dbif.bounce_count), 2);
        check_eq("gl_btn_e6",   32'(dbif.button), 0);
        repeat (10) tick();
        check_eq("gl_btn_late",   32'(dbif.button), 0);
        check_eq("gl_count_late", 32'(dbif.bounce_count), 2);

        // Asynchronous reset with cnt=2 in WAIT_HIGH
        dbif.button_raw = 1'b1;
        repeat (4) tick();
        check_eq("ar_busy_pre", 32'(dbif.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_button",  32'(dbif.button), 0);
        check_eq("ar_press",   32'(dbif.press_pulse), 0);
        check_eq("ar_release", 32'(dbif.release_pulse), 0);
        check_eq("ar_busy",    32'(dbif.busy), 0);
        check_eq("ar_bounce",  32'(dbif.bounce_count), 0);
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_eq($sformatf("ar_btn_e%0d", k), 32'(dbif.button), 32'(k >= 6));
            check_eq($sformatf("ar_pls_e%0d", k), 32'(dbif.press_pulse), 32'(k == 6));
        end

        // Release-side glitch at cnt=3 from IDLE_HIGH, raw returns high
        dbif.button_raw = 1'b0;
        repeat (3) tick();
        dbif.button_raw = 1'b1;
        tick();
        tick();
        check_eq("rg_busy_e5",  32'(dbif.busy), 1);
        tick();
        check_eq("rg_busy_e6",  32'(dbif.busy), 0);
        check_eq("rg_btn_e6",   32'(dbif.button), 1);
        check_eq("rg_rel_e6",   32'(dbif.release_pulse), 0);
        check_eq("rg_count_e6", 32'(dbif.bounce_count), 1);
        repeat (8) tick();
        check_eq("rg_btn_late", 32'(dbif.button), 1);

        // Reset while in IDLE_HIGH drops button at once
        #2 rst_n = 1'b0;
        #1;
        check_eq("rh_button",  32'(dbif.button), 0);
        check_eq("rh_release", 32'(dbif.release_pulse), 0);
        check_eq("rh_bounce",  32'(dbif.bounce_count), 0);
        dbif.button_raw = 1'b0;
        #2 rst_n = 1'b1;
        repeat (4) tick();
        check_eq("rh_btn_after", 32'(dbif.button), 0);

        // Saturation: one abort per 1/0 pair
        for (int i = 0; i < 200; i++) begin
            dbif.button_raw = 1'b1;
            tick();
            dbif.button_raw = 1'b0;
            tick();
        end
        repeat (4) tick();
        check_eq("sat_200", 32'(dbif.bounce_count), 200);
        check_eq("sat_btn_200", 32'(dbif.button), 0);
        for (int i = 0; i < 100; i++) begin
            dbif.button_raw = 1'b1;
            tick();
            dbif.button_raw = 1'b0;
            tick();
        end
        repeat (4) tick();
        check_eq("sat_300", 32'(dbif.bounce_count), 255);
        check_eq("sat_btn_300", 32'(dbif.button), 0);
        for (int i = 0; i < 10; i++) begin
            dbif.button_raw = 1'b1;
            tick();
            dbif.button_raw = 1'b0;
            tick();
        end
        repeat (4) tick();
        check_eq("sat_hold", 32'(dbif.bounce_count), 255);
        check_eq("sat_btn_hold", 32'(dbif.button), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
